// File: rtl/conv_mac.sv
// conv_mac: pipelined signed multiply-accumulate over KSIZE*KSIZE windows with saturated, tagged output
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int KSIZE  = 3,
  parameter int OUT_W  = 8,
  parameter int RELU   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_sum,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] weight,
  input  logic [7:0]               out_idx,
  input  logic                     finish,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [7:0]               out_addr,
  output logic                     sat,
  output logic                     done,
  output logic                     err
);
  localparam int K2 = KSIZE * KSIZE;
  localparam int CW = $clog2(K2 + 1);
  localparam int PW = 2 * DATA_W;
  localparam logic [CW-1:0] LAST = CW'(K2 - 1);
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic fcnt_q, fcnt_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic prod_v_q, prod_v_d, first_q, first_d, last_q, last_d;
  logic [7:0] idx_q, idx_d, out_addr_q, out_addr_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, prod_x, s, r;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, sat_q, sat_d;
  logic live, take, fin, hi, lo, emit;
  // control FSM, element counter and stage-1 product capture; en_sum/finish only count while IDLE/ACCUM
  always_comb begin
    live     = state_q == IDLE || state_q == ACCUM;
    take     = en_sum && live;
    fin      = finish && live;
    cnt_d    = take ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
    state_d  = fin ? FLUSH :
               (state_q == IDLE && take) ? ACCUM :
               (state_q == FLUSH && fcnt_q) ? DONE : state_q;
    fcnt_d   = state_q == FLUSH && !fcnt_q;
    err_d    = err_q | (fin && cnt_d != '0);
    prod_d   = pixel * weight;
    prod_v_d = take;
    first_d  = cnt_q == '0;
    last_d   = cnt_q == LAST;
    idx_d    = out_idx;
  end
  // stage-2 accumulate; the first element of a window reloads so back-to-back windows need no bubble
  always_comb begin
    prod_x      = {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
    s           = (first_q ? {ACC_W{1'b0}} : acc_q) + prod_x;
    acc_d       = prod_v_q ? s : acc_q;
    r           = (RELU != 0 && s < 0) ? {ACC_W{1'b0}} : s;
    hi          = r > SMAX;
    lo          = r < SMIN;
    emit        = prod_v_q && last_q;
    out_valid_d = emit;
    out_data_d  = emit ? (hi ? SMAX[OUT_W-1:0] : lo ? SMIN[OUT_W-1:0] : r[OUT_W-1:0]) : out_data_q;
    sat_d       = emit ? (hi | lo) : sat_q;
    out_addr_d  = emit ? idx_q : out_addr_q;
  end
  // state registers, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fcnt_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      prod_q      <= '0;
      prod_v_q    <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      prod_v_q    <= prod_v_d;
      first_q     <= first_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      sat_q       <= sat_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign sat       = sat_q;
  assign done      = state_q == DONE;
  assign err       = err_q;
endmodule

// File: tb/tb_conv_mac.sv
// tb_conv_mac: directed self-checking bench for conv_mac (RELU=0 and RELU=1 instances share stimulus)
module tb_conv_mac;
  logic clk = 1'b0;
  logic reset, en_sum, finish;
  logic signed [7:0] pixel, weight;
  logic [7:0] out_idx;
  logic ov, sat, done, err, ov_r, sat_r, done_r, err_r;
  logic signed [7:0] od, od_r;
  logic [7:0] oa, oa_r;
  int checks = 0;
  int failures = 0;

  conv_mac dut (.clk(clk), .reset(reset), .en_sum(en_sum), .pixel(pixel), .weight(weight),
    .out_idx(out_idx), .finish(finish), .out_valid(ov), .out_data(od), .out_addr(oa),
    .sat(sat), .done(done), .err(err));

  conv_mac #(.RELU(1)) dut_r (.clk(clk), .reset(reset), .en_sum(en_sum), .pixel(pixel), .weight(weight),
    .out_idx(out_idx), .finish(finish), .out_valid(ov_r), .out_data(od_r), .out_addr(oa_r),
    .sat(sat_r), .done(done_r), .err(err_r));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic signed [7:0] p, input logic signed [7:0] w,
                      input logic [7:0] i, input logic f);
    @(negedge clk);
    en_sum = e; pixel = p; weight = w; out_idx = i; finish = f;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; en_sum = 1'b0; finish = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic win(input logic signed [7:0] p, input logic signed [7:0] w, input logic [7:0] i,
                     input int ed, input int es, input int edr, input int esr);
    for (int k = 0; k < 9; k++) step(1'b1, p, w, i, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0);
    chk("valid_early", ov, 0);
    step(1'b0, 0, 0, 0, 1'b0);
    chk("valid", ov, 1);
    chk("data", od, ed);
    chk("addr", oa, i);
    chk("sat", sat, es);
    chk("relu_valid", ov_r, 1);
    chk("relu_data", od_r, edr);
    chk("relu_sat", sat_r, esr);
    step(1'b0, 0, 0, 0, 1'b0);
    chk("valid_pulse_end", ov, 0);
  endtask

  initial begin
    reset = 1'b0; en_sum = 1'b0; finish = 1'b0; pixel = '0; weight = '0; out_idx = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", ov, 0);
    chk("rst_data", od, 0);
    chk("rst_addr", oa, 0);
    chk("rst_sat", sat, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    win(1, 1, 5, 9, 0, 9, 0);
    win(127, 127, 1, 127, 1, 127, 1);
    win(-128, 127, 2, -128, 1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(k < 18, 2, (k < 9) ? 8'sd1 : -8'sd1, (k < 9) ? 8'd3 : 8'd4, 1'b0);
      chk("b2b_valid", ov, (k == 10 || k == 19) ? 1 : 0);
      if (k == 10) begin
        chk("b2b_data0", od, 18);
        chk("b2b_addr0", oa, 3);
      end
      if (k == 19) begin
        chk("b2b_data1", od, -18);
        chk("b2b_addr1", oa, 4);
      end
    end
    for (int k = 0; k < 15; k++) begin
      step(k < 4 || (k >= 7 && k < 12), 1, 1, 6, 1'b0);
      chk("gap_valid", ov, (k == 13) ? 1 : 0);
      if (k == 13) chk("gap_data", od, 9);
    end
    for (int k = 0; k < 5; k++) step(1'b1, 3, 3, 8, 1'b0);
    @(negedge clk);
    reset = 1'b0; en_sum = 1'b0;
    #1;
    chk("midrst_valid", ov, 0);
    chk("midrst_data", od, 0);
    chk("midrst_addr", oa, 0);
    chk("midrst_sat", sat, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    @(negedge clk);
    reset = 1'b1;
    win(1, 1, 7, 9, 0, 9, 0);
    for (int k = 0; k < 4; k++) step(1'b1, 1, 1, 9, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1);
    for (int k = 5; k < 10; k++) begin
      step(1'b0, 0, 0, 0, 1'b0);
      chk("part_valid", ov, 0);
      chk("part_done", done, (k >= 7) ? 1 : 0);
      if (k == 7) begin
        chk("part_err", err, 1);
        chk("part_err_relu", err_r, 1);
      end
    end
    do_reset();
    chk("rst2_done", done, 0);
    chk("rst2_err", err, 0);
    for (int k = 0; k < 9; k++) step(1'b1, 1, 1, 11, k == 8);
    for (int k = 9; k < 12; k++) begin
      step(1'b0, 0, 0, 0, 1'b0);
      chk("fin_valid", ov, (k == 10) ? 1 : 0);
      chk("fin_done", done, (k >= 11) ? 1 : 0);
      if (k == 10) begin
        chk("fin_data", od, 9);
        chk("fin_addr", oa, 11);
      end
      if (k == 11) chk("fin_err", err, 0);
    end
    for (int k = 0; k < 3; k++) step(1'b1, 5, 5, 12, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0);
    chk("done_ignores_en", ov, 0);
    chk("done_sticky", done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
